// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states, nibble width, default datapath width.
// Pure declarations; no logic or latency of its own.
// No handshake; consumers own their flow control.
package alu_pkg;

  typedef enum logic {IDLE, CALC} state_t;

  localparam int NIBBLE_W = 4;
  localparam int DATA_W   = 16;

  // Nibble-index counter width for a given number of steps (at least one bit).
  function automatic int idx_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  localparam int K_W = idx_w(DATA_W / NIBBLE_W);

endpackage

// File: rtl/sub4bit.sv
// 4-bit borrow-lookahead subtractor: {bo, d4} = a4 - b4 - bi.
// Purely combinational, zero cycles.
// No handshake; evaluated whenever the operands change.
import alu_pkg::*;

module sub4bit (
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                bi,
  output logic [NIBBLE_W-1:0] d4,
  output logic                bo
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  // Generate: this bit borrows on its own. Propagate: an incoming borrow passes through.
  assign g = ~a4 & b4;
  assign p = ~(a4 ^ b4);

  // Flattened lookahead so every borrow depends only on g, p and bi.
  assign c[0] = bi;
  assign c[1] = g[0] | (p[0] & bi);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d4 = a4 ^ b4 ^ c[NIBBLE_W-1:0];
  assign bo = c[NIBBLE_W];

endmodule

// File: rtl/sub16_seq.sv
// Sequential W-bit subtractor a - b - bin, one nibble per clock LSB first; flags enabled by SUB16_FLAGS_EN.
// Latency N=W/4 cycles from accept to the one-cycle done pulse; new op every N+1 edges.
// ready is high only in IDLE; start while busy is ignored (no queueing).
import alu_pkg::*;

module sub16_seq #(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         done,
  output logic         zf,
  output logic         nf,
  output logic         vf
);

  localparam int N  = W / NIBBLE_W;
  localparam int KW = idx_w(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t                           state;
  logic [KW-1:0]                    k;
  logic [N-1:0][NIBBLE_W-1:0]       a_r;
  logic [N-1:0][NIBBLE_W-1:0]       b_r;
  logic [N-1:0][NIBBLE_W-1:0]       part_r;
  logic [N-1:0][NIBBLE_W-1:0]       part_next;
  logic                             br;
  logic [NIBBLE_W-1:0]              d4;
  logic                             bo;

  assign ready = (state == IDLE);

  // One nibble stage shared by all steps; k selects which nibble it sees.
  sub4bit u_nib (
    .a4 (a_r[k]),
    .b4 (b_r[k]),
    .bi (br),
    .d4 (d4),
    .bo (bo)
  );

  // Partial result with the current nibble merged, so completion captures all N nibbles.
  always_comb begin
    part_next    = part_r;
    part_next[k] = d4;
  end

  // Sequencer: latch operands on accept, step one nibble per edge, publish at the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      k      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      part_r <= '0;
      br     <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            br     <= bin;
            part_r <= '0;
            k      <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          part_r[k] <= d4;
          br        <= bo;
          k         <= k + 1'b1;
          if (k == K_LAST) begin
            diff  <= part_next;
            bout  <= bo;
            done  <= 1'b1;
            k     <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUB16_FLAGS_EN
  // Status flags captured at the same completion edge as diff; a_r/b_r still hold the operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zf <= 1'b0;
      nf <= 1'b0;
      vf <= 1'b0;
    end else if (state == CALC && k == K_LAST) begin
      zf <= (part_next == '0);
      nf <= part_next[N-1][NIBBLE_W-1];
      vf <= (a_r[N-1][NIBBLE_W-1] != b_r[N-1][NIBBLE_W-1]) &&
            (part_next[N-1][NIBBLE_W-1] != a_r[N-1][NIBBLE_W-1]);
    end
  end
`else
  assign zf = 1'b0;
  assign nf = 1'b0;
  assign vf = 1'b0;
`endif

endmodule

// File: tb/tb_sub16_seq.sv
// Directed bench for sub16_seq: hand-computed vectors, handshake timing, reset abort.
// Flag expectations follow whether SUB16_FLAGS_EN is defined for this build.
// Outputs are sampled 1 time unit after the rising edge.
module tb_sub16_seq;

`ifdef SUB16_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic [15:0] a, b, diff;
  logic        bin, bout, done, zf, nf, vf;

  int nvec  = 0;
  int nfail = 0;
  int edges;

  sub16_seq #(.W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .done  (done),
    .zf    (zf),
    .nf    (nf),
    .vf    (vf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count edges from accept until done rises (bounded).
  task automatic wait_done(input string tag);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done && edges < 12);
    chk({tag, "_lat"}, edges, 4);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] ed, input logic eb,
                         input logic ez, input logic en, input logic ev);
    chk({tag, "_done"},  done,  1'b1);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_diff"},  diff,  ed);
    chk({tag, "_bout"},  bout,  eb);
    chk({tag, "_zf"},    zf,    ez & FL);
    chk({tag, "_nf"},    nf,    en & FL);
    chk({tag, "_vf"},    vf,    ev & FL);
  endtask

  // Issue one operation from the current (post-edge) time and wait for its result.
  task automatic run(input string tag, input logic [15:0] ia, input logic [15:0] ib, input logic ibin);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_diff", diff, 16'h0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {zf, nf, vf}, 3'b000);
    chk("rst_ready", ready, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;

    run("t20m5", 16'd20, 16'd5, 1'b1);
    chk_res("t20m5", 16'd14, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: issued in the done cycle.
    run("b2b", 16'd100, 16'd1, 1'b0);
    chk_res("b2b", 16'd99, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);

    run("under", 16'h0000, 16'h0001, 1'b0);
    chk_res("under", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run("zero", 16'h1234, 16'h1234, 1'b0);
    chk_res("zero", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run("ovf1", 16'h8000, 16'h0001, 1'b0);
    chk_res("ovf1", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run("ovf2", 16'h7FFF, 16'hFFFF, 1'b0);
    chk_res("ovf2", 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

    // start held through CALC with operands changing: only the latched pair counts.
    a = 16'h0050; b = 16'h0030; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("busy_ready", ready, 1'b0);
      chk("busy_done", done, 1'b0);
      if (i == 1) chk("hold_diff", diff, 16'h8000);
      a = 16'(i * 16'h1111 + 16'h0F0F);
      b = 16'(i * 16'h2222 + 16'h0101);
      bin = ~bin;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk_res("held", 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("held_noreacc", ready, 1'b1);
    chk("held_pulse", done, 1'b0);

    // Reset in the second CALC cycle aborts the operation.
    a = 16'h00FF; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_diff", diff, 16'h0);
    chk("abort_bout", bout, 1'b0);
    chk("abort_flags", {zf, nf, vf}, 3'b000);
    chk("abort_ready", ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) edges++;
    end
    chk("abort_nodone", edges, 0);
    chk("abort_ready2", ready, 1'b1);
    chk("abort_diff2", diff, 16'h0);

    run("post", 16'hABCD, 16'h1234, 1'b1);
    chk_res("post", 16'h9998, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
